b_operand_sequencer: RTL and testbench
======================================

# b_operand_sequencer

Controller for the dual B register pipeline of the DSP slice. It arbitrates between two operand sources, fabric B and cascade BCIN, and drives the cascade-select mux and the CEB1/CEB2 clock enables. It tracks a valid/tag pipeline matching the configured B register depth, and runs a coefficient-hold mode in which B1 keeps a multiplier coefficient while B2 streams X-path operands. It sits beside the B register datapath and is the only driver of its enables, input select and INMODE.

## Interface
- BREG, 1, B pipeline depth (0, 1, 2); must equal the datapath BREG.
- TAGW, 4, width of the operand tag carried alongside the data.
- CLK_B1  in  1  clock (ungated; the datapath gates it with CEB1/CEB2)
- RSTB  in  1  reset, synchronous, active-high
- REQ_F  in  1  fabric source has an operand on B
- TAG_F  in  TAGW  tag of the fabric operand
- GNT_F  out  1  fabric operand is sampled at the next edge
- REQ_C  in  1  cascade source has an operand on BCIN
- TAG_C  in  TAGW  tag of the cascade operand
- GNT_C  out  1  cascade operand is sampled at the next edge
- STALL  in  1  downstream hold
- COEF_LOAD  in  1  pulse: the next granted operand becomes the held coefficient
- COEF_CLR  in  1  pulse: leave coefficient mode
- B_INPUT_SEL  out  1  datapath input mux select (0 = B, 1 = BCIN)
- CEB1, CEB2  out  1  datapath register enables
- INMODE  out  1  1 = BMULT taken from B1
- OUT_VALID  out  1  operand present at XMUX/BMULT this cycle
- OUT_TAG  out  TAGW  tag of that operand
- COEF_VALID  out  1  B1 holds a valid coefficient

## Operation
- Arbiter: round-robin between the two sources; at most one grant per cycle.
  - GNT_x = REQ_x & !STALL & !RSTB & (pointer==x | !REQ_other). All grant terms are combinational.
  - The pointer moves to the other source after each grant. Reset pointer = F.
- B_INPUT_SEL = GNT_C, combinational; it is 0 when there is no grant.
- Valid pipe: BREG stages of {valid, tag}.
  - On a non-stalled cycle stage 0 loads {grant, granted tag} and the stages shift. A cycle with no grant inserts a bubble.
  - STALL freezes the pipe.
  - OUT_VALID/OUT_TAG come from the last stage. With BREG=0 they are the combinational grant and tag.
- Enables in STREAM:
  - BREG=2: CEB1 = CEB2 = !STALL.
  - BREG=1: CEB1 = 0, CEB2 = !STALL.
  - BREG=0: both 0.
- Coefficient FSM: states STREAM, ARM, HOLD, RELOAD. It is active only when BREG=1; for other depths COEF_LOAD is ignored and the FSM stays in STREAM.
  - STREAM: on COEF_LOAD go to ARM. INMODE=0.
  - ARM / RELOAD: the first grant is a capture cycle. On that cycle CEB1=1, CEB2=0, the pipe is frozen and the tag is dropped (OUT_VALID is not produced for it); the FSM then goes to HOLD.
  - ARM / RELOAD, other cycles: CEB1=0 and B2 streams.
  - HOLD: CEB1=0, CEB2=!STALL, INMODE=1. On COEF_LOAD go to RELOAD.
  - INMODE=1 in HOLD and RELOAD, so the old coefficient stays in use until it is replaced.
  - COEF_VALID=1 in HOLD and RELOAD.
  - COEF_CLR from any state goes to STREAM. If COEF_CLR and COEF_LOAD are high in the same cycle, COEF_CLR wins.
  - A STALL during ARM or RELOAD delays the capture; there is no grant while stalled.

## Timing
- Reset (RSTB=1 at an edge):
  - State goes to STREAM, pointer to F, and the pipe clears.
  - Next cycle: OUT_VALID=0, OUT_TAG=0, INMODE=0, COEF_VALID=0.
  - While RSTB=1: GNT=0, B_INPUT_SEL=0, CEB1=CEB2=1, so the datapath registers see the edge and clear.
- A reset asserted mid-stream or mid-capture discards all in-flight tags and any held coefficient.
- Latency: an operand granted in cycle t gives OUT_VALID in cycle t+BREG (non-stalled cycles only). Each STALL cycle adds one.
- Throughput is one operand per cycle. With both sources requesting, grants alternate F, C, F, C….
- INMODE changes on the edge that completes the FSM transition. B1 is captured on the same edge that enters HOLD.

## Test plan
- BREG=2. REQ_F held with tags 1, 2, 3, REQ_C=0, no stall → GNT_F in cycles 0–2; OUT_VALID in cycles 2–4 with tags 1, 2, 3; CEB1=CEB2=1.
- BREG=1. REQ_F and REQ_C both held, tags F=0xA and C=0x5 → grants F, C, F, C; B_INPUT_SEL 0, 1, 0, 1; OUT_TAG 0xA, 0x5, … one cycle later.
- BREG=2, stream running. STALL high for 3 cycles mid-stream → no grants, CEB1=CEB2=0, OUT_VALID/OUT_TAG frozen; the stream resumes in order with no lost or duplicated tags.
- BREG=1. COEF_LOAD pulse, then REQ_F with tag 7, then tags 8 and 9 → capture cycle has CEB1=1, CEB2=0 and tag 7 never appears at the output; INMODE=1 and COEF_VALID=1 afterwards; OUT_TAG 8, 9 with CEB1=0.
- BREG=1, in HOLD. COEF_LOAD and COEF_CLR high in the same cycle → next state STREAM, INMODE=0, COEF_VALID=0.
- BREG=2, two operands in flight. RSTB pulsed → the following cycle has OUT_VALID=0 and the pointer at F; the next simultaneous request is granted to F.

Source files
------------

// File: rtl/b_operand_sequencer_if.sv
// Operand source handshake for the B register sequencer: fabric (B) and
// cascade (BCIN) request/tag lines plus their grants.
interface b_operand_sequencer_if #(
  parameter int TAGW = 4
);
  logic            REQ_F;
  logic [TAGW-1:0] TAG_F;
  logic            GNT_F;
  logic            REQ_C;
  logic [TAGW-1:0] TAG_C;
  logic            GNT_C;

  // Operand sources drive requests and tags and observe grants.
  modport master (
    output REQ_F, TAG_F, REQ_C, TAG_C,
    input  GNT_F, GNT_C
  );

  // The sequencer observes requests and tags and issues grants.
  modport slave (
    input  REQ_F, TAG_F, REQ_C, TAG_C,
    output GNT_F, GNT_C
  );
endinterface

// File: rtl/b_operand_sequencer.sv
// Controller for the dual B register pipeline: round-robin arbitration between
// fabric B and cascade BCIN, CEB1/CEB2/INMODE generation, a valid/tag pipe that
// mirrors the datapath BREG depth, and a coefficient-hold mode (BREG=1 only)
// in which B1 keeps a multiplier coefficient while B2 streams operands.
module b_operand_sequencer #(
  parameter int BREG = 1,
  parameter int TAGW = 4
) (
  input  logic                 CLK_B1,
  input  logic                 RSTB,
  b_operand_sequencer_if.slave src,
  input  logic                 STALL,
  input  logic                 COEF_LOAD,
  input  logic                 COEF_CLR,
  output logic                 B_INPUT_SEL,
  output logic                 CEB1,
  output logic                 CEB2,
  output logic                 INMODE,
  output logic                 OUT_VALID,
  output logic [TAGW-1:0]      OUT_TAG,
  output logic                 COEF_VALID
);

  typedef enum logic [1:0] {
    ST_STREAM,
    ST_ARM,
    ST_HOLD,
    ST_RELOAD
  } coef_state_e;

  typedef enum logic {
    SRC_F,
    SRC_C
  } src_e;

  // Coefficient hold needs B1 to be separately enabled from the output stage,
  // which only the single-register configuration provides.
  localparam bit COEF_EN = (BREG == 1);

  src_e            ptr_q, ptr_d;
  coef_state_e     state_q, state_d;
  logic            grant_f, grant_c, grant_any;
  logic [TAGW-1:0] grant_tag;
  logic            capture;

  // Round robin: the pointer side wins a tie; a lone requester always wins.
  assign grant_f   = src.REQ_F & ~STALL & ~RSTB & ((ptr_q == SRC_F) | ~src.REQ_C);
  assign grant_c   = src.REQ_C & ~STALL & ~RSTB & ((ptr_q == SRC_C) | ~src.REQ_F);
  assign grant_any = grant_f | grant_c;
  assign grant_tag = grant_c ? src.TAG_C : (grant_f ? src.TAG_F : '0);

  assign src.GNT_F = grant_f;
  assign src.GNT_C = grant_c;
  assign B_INPUT_SEL = grant_c;

  // The first grant while arming or reloading is steered into B1 instead of the stream.
  assign capture = COEF_EN & ((state_q == ST_ARM) | (state_q == ST_RELOAD)) & grant_any;

  // Pointer hands priority to the other source after every grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    if (grant_f)      ptr_d = SRC_C;
    else if (grant_c) ptr_d = SRC_F;
  end

  // Coefficient mode sequencing; clear beats load, reset is applied in the register.
  always_comb begin
    state_d = state_q;
    if (!COEF_EN || COEF_CLR) begin
      state_d = ST_STREAM;
    end else begin
      case (state_q)
        ST_STREAM: if (COEF_LOAD) state_d = ST_ARM;
        ST_ARM:    if (capture)   state_d = ST_HOLD;
        ST_HOLD:   if (COEF_LOAD) state_d = ST_RELOAD;
        ST_RELOAD: if (capture)   state_d = ST_HOLD;
        default:                  state_d = ST_STREAM;
      endcase
    end
  end

  // Control state registers with the codebase's synchronous active-high reset.
  always_ff @(posedge CLK_B1) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    if (RSTB) begin
      ptr_q   <= SRC_F;
      state_q <= ST_STREAM;
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
    end
  end

  // Datapath enables: forced on in reset so the B registers clear, capture loads B1 only.
  always_comb begin
    CEB1 = 1'b0;
    CEB2 = 1'b0;
    if (RSTB) begin
      CEB1 = 1'b1;
      CEB2 = 1'b1;
    end else if (capture) begin
      CEB1 = 1'b1;
    end else if (BREG == 2) begin
      CEB1 = ~STALL;
      CEB2 = ~STALL;
    end else if (BREG == 1) begin
      CEB2 = ~STALL;
    end
  end

  // The old coefficient stays selected during RELOAD until its replacement lands in B1.
  assign INMODE     = (state_q == ST_HOLD) | (state_q == ST_RELOAD);
  assign COEF_VALID = INMODE;

  generate
    if (BREG == 0) begin : g_no_pipe
      assign OUT_VALID = grant_any;
      assign OUT_TAG   = grant_tag;
    end else begin : g_pipe
      logic            vld_q [BREG];
      logic [TAGW-1:0] tag_q [BREG];
      logic            advance;

      // Stall and the coefficient capture both hold B2, so the tag pipe holds too.
      assign advance = ~STALL & ~capture;

      // Valid/tag shift register tracking the datapath B registers.
      always_ff @(posedge CLK_B1) begin
        // NOTE: the pipe arrays are reset because in-flight tags must be discarded on reset.
        if (RSTB) begin
          for (int i = 0; i < BREG; i++) begin
            vld_q[i] <= 1'b0;
            tag_q[i] <= '0;
          end
        end else if (advance) begin
          vld_q[0] <= grant_any;
          tag_q[0] <= grant_tag;
          for (int i = 1; i < BREG; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end

      assign OUT_VALID = vld_q[BREG-1];
      assign OUT_TAG   = tag_q[BREG-1];
    end
  endgenerate

endmodule

// File: tb/tb_b_operand_sequencer.sv
// Bench for b_operand_sequencer: one instance per BREG depth (0, 1, 2) fed the
// same stimulus. Each depth has a reference model that predicts grants and
// enables every cycle and pushes expected output tags into a scoreboard queue;
// a separate monitor pops and compares whenever the output is due.
module tb_b_operand_sequencer;

  localparam int M_STREAM = 0;
  localparam int M_ARM    = 1;
  localparam int M_HOLD   = 2;
  localparam int M_RELOAD = 3;

  typedef struct {
    logic [3:0] tag;
    int         rem;
  } exp_t;

  logic       clk;
  logic       rstb, stall, coef_load, coef_clr;
  logic       req_f, req_c;
  logic [3:0] tag_f, tag_c;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D = gi;

    b_operand_sequencer_if #(.TAGW(4)) bif();
    assign bif.REQ_F = req_f;
    assign bif.TAG_F = tag_f;
    assign bif.REQ_C = req_c;
    assign bif.TAG_C = tag_c;

    logic       b_sel, ceb1, ceb2, inmode, out_valid, coef_valid;
    logic [3:0] out_tag;

    b_operand_sequencer #(.BREG(D), .TAGW(4)) dut (
      .CLK_B1     (clk),
      .RSTB       (rstb),
      .src        (bif),
      .STALL      (stall),
      .COEF_LOAD  (coef_load),
      .COEF_CLR   (coef_clr),
      .B_INPUT_SEL(b_sel),
      .CEB1       (ceb1),
      .CEB2       (ceb2),
      .INMODE     (inmode),
      .OUT_VALID  (out_valid),
      .OUT_TAG    (out_tag),
      .COEF_VALID (coef_valid)
    );

    exp_t exp_q[$];
    int   ptr   = 0;   // 0 = fabric has priority, 1 = cascade
    int   mode  = M_STREAM;
    bit   init  = 0;
    bit   chk   = 0;
    bit   adv   = 0;
    bit   rst_now  = 0;
    bit   post_rst = 0;

    // Reference model: evaluated mid-cycle from the inputs about to be clocked in.
    always @(negedge clk) begin
      bit gf, gc, cap, e1, e2, hold_coef;
      chk = init;
      gf = 0;
      gc = 0;
      if (!rstb && !stall) begin
        if (req_f && req_c) begin
          if (ptr == 0) gf = 1; else gc = 1;
        end else begin
          gf = req_f;
          gc = req_c;
        end
      end
      cap = (D == 1) && (mode == M_ARM || mode == M_RELOAD) && (gf || gc);
      if (rstb)        begin e1 = 1; e2 = 1;      end
      else if (cap)    begin e1 = 1; e2 = 0;      end
      else if (D == 2) begin e1 = !stall; e2 = !stall; end
      else if (D == 1) begin e1 = 0; e2 = !stall; end
      else             begin e1 = 0; e2 = 0;      end
      hold_coef = (mode == M_HOLD || mode == M_RELOAD);

      if (chk) begin
        check($sformatf("B%0d gnt_f", D), 32'(bif.GNT_F), 32'(gf));
        check($sformatf("B%0d gnt_c", D), 32'(bif.GNT_C), 32'(gc));
        check($sformatf("B%0d b_input_sel", D), 32'(b_sel), 32'(gc));
        check($sformatf("B%0d ceb1", D), 32'(ceb1), 32'(e1));
        check($sformatf("B%0d ceb2", D), 32'(ceb2), 32'(e2));
        check($sformatf("B%0d inmode", D), 32'(inmode), 32'(hold_coef));
        check($sformatf("B%0d coef_valid", D), 32'(coef_valid), 32'(hold_coef));
      end

      if (!rstb && !cap && (gf || gc))
        exp_q.push_back('{tag: (gc ? tag_c : tag_f), rem: D});
      adv     = !rstb && !stall && !cap;
      rst_now = rstb;

      if (rstb) begin
        ptr  = 0;
        mode = M_STREAM;
        init = 1;
      end else begin
        if (gf) ptr = 1;
        if (gc) ptr = 0;
        if (D != 1 || coef_clr) mode = M_STREAM;
        else if (mode == M_STREAM && coef_load) mode = M_ARM;
        else if (mode == M_HOLD && coef_load)   mode = M_RELOAD;
        else if (cap)                           mode = M_HOLD;
      end
    end

    // Monitor: compares the presented output against the scoreboard head.
    always @(negedge clk) begin
      #2;
      if (chk) begin
        if (exp_q.size() > 0 && exp_q[0].rem == 0) begin
          check($sformatf("B%0d out_valid", D), 32'(out_valid), 32'd1);
          check($sformatf("B%0d out_tag", D), 32'(out_tag), 32'(exp_q[0].tag));
        end else begin
          check($sformatf("B%0d out_valid", D), 32'(out_valid), 32'd0);
          if (post_rst) check($sformatf("B%0d out_tag after reset", D), 32'(out_tag), 32'd0);
        end
      end
      post_rst = rst_now;
      if (rst_now) begin
        exp_q.delete();
      end else if (adv) begin
        if (exp_q.size() > 0 && exp_q[0].rem == 0) void'(exp_q.pop_front());
        foreach (exp_q[i]) if (exp_q[i].rem > 0) exp_q[i].rem--;
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic ld, input logic cl,
                      input logic rf, input logic [3:0] tf,
                      input logic rc, input logic [3:0] tc);
    rstb      = r;
    stall     = s;
    coef_load = ld;
    coef_clr  = cl;
    req_f     = rf;
    tag_f     = tf;
    req_c     = rc;
    tag_c     = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 1, 4'h3, 1, 4'h4);
    // Fabric only, tags 1, 2, 3
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 1, 4'(i), 0, 4'h0);
    idle(4);
    // Both sources: alternating F, C, F, C
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 4'hA, 1, 4'h5);
    idle(3);
    // Stream with a three-cycle stall in the middle
    for (int i = 0; i < 8; i++) step(0, (i >= 3 && i < 6), 0, 0, 1, 4'(i + 1), 0, 4'h0);
    idle(3);
    // Coefficient load: tag 7 captured, 8 and 9 streamed
    step(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
    step(0, 0, 0, 0, 1, 4'h7, 0, 4'h0);
    step(0, 0, 0, 0, 1, 4'h8, 0, 4'h0);
    step(0, 0, 0, 0, 1, 4'h9, 0, 4'h0);
    idle(3);
    // Reload with a stalled capture, then stream from cascade
    step(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
    step(0, 1, 0, 0, 1, 4'hB, 0, 4'h0);
    step(0, 0, 0, 0, 1, 4'hB, 0, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0, 1, 4'hC);
    idle(2);
    // Load and clear together in HOLD: clear wins
    step(0, 0, 1, 1, 0, 4'h0, 0, 4'h0);
    idle(2);
    // Reset with two operands in flight, then a simultaneous request
    step(0, 0, 0, 0, 1, 4'h1, 1, 4'h2);
    step(0, 0, 0, 0, 1, 4'h1, 1, 4'h2);
    step(1, 0, 0, 0, 1, 4'h1, 1, 4'h2);
    step(0, 0, 0, 0, 1, 4'h3, 1, 4'h4);
    step(0, 0, 0, 0, 1, 4'h3, 1, 4'h4);
    idle(3);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 4'($urandom),
           ($urandom_range(0, 9) < 7), 4'($urandom));
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "watchdog");
  end

endmodule
